// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              RXD,
    input  logic                              rd_en,
    input  logic                              clr_err,
    output logic [7:0]                        rd_data,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              frame_err,
    output logic                              overrun,
    output logic                              parity_err
);

    localparam int CPB = CLK_FREQ_HZ / BAUD;
    localparam int BW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] HALF = BW'(CPB / 2 - 1);
    localparam logic [BW-1:0] FULL = BW'(CPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic            r_sync;
    logic            r_rxs;
    logic            r_rxs_d;
    logic [BW-1:0]   r_bcnt;
    logic [BW-1:0]   w_bcnt_n;
    logic [2:0]      r_bitidx;
    logic [2:0]      w_bitidx_n;
    logic [7:0]      r_shreg;
    logic [7:0]      w_shreg_n;
    logic            w_sample;
    logic            w_push_req;
    logic            w_set_fe;
    logic            w_par_ok;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf;
    logic            r_fe;
    logic            r_ovr;

`ifdef UART_RX_PARITY_EN
    logic            w_set_pe;
    logic            r_par_bad;
    logic            r_pe;
    assign w_par_ok = !r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    // RXD is asynchronous; the edge detector sees only the synchronized copy
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync  <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= RXD;
            r_rxs   <= r_sync;
            r_rxs_d <= r_rxs;
        end
    end

    assign w_sample = (r_bcnt == '0);

    always_comb begin
        w_state_n  = r_state;
        w_bcnt_n   = r_bcnt - BW'(1);
        w_bitidx_n = r_bitidx;
        w_shreg_n  = r_shreg;
        w_push_req = 1'b0;
        w_set_fe   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_set_pe   = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (r_rxs_d && !r_rxs) begin
                    w_state_n = S_START;
                    w_bcnt_n  = HALF;
                end
            end
            S_START: begin
                if (w_sample) begin
                    w_bcnt_n = FULL;
                    if (!r_rxs) begin
                        w_state_n  = S_DATA;
                        w_bitidx_n = 3'd0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shreg_n  = {r_rxs, r_shreg[7:1]};
                    w_bitidx_n = r_bitidx + 3'd1;
                    w_bcnt_n   = FULL;
                    if (r_bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_sample) begin
                    w_set_pe  = (r_rxs != ^r_shreg);
                    w_state_n = S_STOP;
                    w_bcnt_n  = FULL;
                end
            end
`endif
            S_STOP: begin
                if (w_sample) begin
                    w_push_req = r_rxs && w_par_ok;
                    w_set_fe   = !r_rxs;
                    w_state_n  = S_IDLE;
                    w_bcnt_n   = FULL;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_bcnt_n  = FULL;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_bcnt   <= FULL;
            r_bitidx <= 3'd0;
            r_shreg  <= 8'h00;
        end else begin
            r_state  <= w_state_n;
            r_bcnt   <= w_bcnt_n;
            r_bitidx <= w_bitidx_n;
            r_shreg  <= w_shreg_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_par_bad <= 1'b0;
            r_pe      <= 1'b0;
        end else begin
            if (r_state == S_PARITY && w_sample)
                r_par_bad <= w_set_pe;
            r_pe <= w_set_pe | (r_pe & ~clr_err);
        end
    end
    assign parity_err = r_pe;
`else
    assign parity_err = 1'b0;
`endif

    // A push into a full FIFO still lands when the head is popped that cycle
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = rd_en && (r_count != '0);
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_ovf  = w_push_req && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wptr] <= r_shreg;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            r_fe  <= w_set_fe | (r_fe & ~clr_err);
            r_ovr <= w_ovf | (r_ovr & ~clr_err);
        end
    end

    assign valid     = (r_count != '0);
    assign count     = r_count;
    assign rd_data   = valid ? r_mem[r_rptr] : 8'h00;
    assign frame_err = r_fe;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of uart_rx_fifo at 10 clocks per bit.
// Define UART_RX_PARITY_EN to also exercise the 8E1 parity path.
module tb_uart_rx_fifo;

    logic       CLK;
    logic       RESET;
    logic       RXD;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       valid;
    logic [3:0] count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(
        .CLK_FREQ_HZ(1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RXD       (RXD),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .valid     (valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        RXD = v;
        repeat (10) step();
    endtask

    task automatic send_head(input logic [7:0] b, input logic bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ bad_par);
`else
        if (bad_par)
            $fatal(1, "parity stimulus needs the parity build");
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v,
                             input logic bad_par);
        send_head(b, bad_par);
        drive_bit(stop_v);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        RESET   = 1'b0;
        RXD     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) step();
        chk("rst_valid", valid, 0);
        chk("rst_count", count, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_pe", parity_err, 0);
        RESET = 1'b1;
        repeat (5) step();

        // 0xA5 with exact push latency around the stop sample
        send_head(8'hA5, 1'b0);
        RXD = 1'b1;
        repeat (7) step();
        chk("a5_pre_valid", valid, 0);
        step();
        chk("a5_valid", valid, 1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_count", count, 1);
        repeat (22) step();
        pop();
        chk("a5_pop_valid", valid, 0);
        chk("a5_pop_count", count, 0);

        rd_en = 1'b1;
        repeat (2) step();
        rd_en = 1'b0;
        chk("empty_pop_count", count, 0);
        chk("empty_pop_valid", valid, 0);

        // short low glitch rejected at the start-bit sample
        RXD = 1'b0;
        repeat (3) step();
        RXD = 1'b1;
        repeat (20) step();
        chk("glitch_count", count, 0);
        chk("glitch_fe", frame_err, 0);
        chk("glitch_ovr", overrun, 0);
        chk("glitch_pe", parity_err, 0);
        send_byte(8'h3C, 1'b1, 1'b0);
        chk("post_glitch_data", rd_data, 8'h3C);
        chk("post_glitch_count", count, 1);
        pop();

        send_byte(8'h3C, 1'b0, 1'b0);
        chk("fe_set", frame_err, 1);
        chk("fe_count", count, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("fe_clr", frame_err, 0);

        for (int i = 1; i <= 9; i++)
            send_byte(8'(i), 1'b1, 1'b0);
        chk("ovr_count", count, 8);
        chk("ovr_flag", overrun, 1);
        chk("ovr_head", rd_data, 8'h01);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovr_clr", overrun, 0);

        // push into a full FIFO while popping: both happen, no overrun
        send_head(8'h0A, 1'b0);
        RXD = 1'b1;
        repeat (7) step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("full_pp_count", count, 8);
        chk("full_pp_ovr", overrun, 0);
        repeat (22) step();
        for (int i = 2; i <= 8; i++) begin
            chk($sformatf("drain_%0d", i), rd_data, i);
            pop();
        end
        chk("drain_last", rd_data, 8'h0A);
        pop();
        chk("drain_valid", valid, 0);
        chk("drain_count", count, 0);

        // reset in the middle of data bit 4 of 0xFF
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        chk("pre_rst_count", count, 1);
        chk("pre_rst_fe", frame_err, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(1'b1);
        repeat (5) step();
        RESET = 1'b0;
        repeat (2) step();
        chk("mid_rst_count", count, 0);
        RESET = 1'b1;
        repeat (40) step();
        chk("post_rst_valid", valid, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_data", rd_data, 0);
        chk("post_rst_fe", frame_err, 0);
        send_byte(8'h55, 1'b1, 1'b0);
        chk("post_rst_55", rd_data, 8'h55);
        chk("post_rst_55_count", count, 1);
        pop();

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1'b1, 1'b1);
        chk("par_bad_pe", parity_err, 1);
        chk("par_bad_count", count, 0);
        chk("par_bad_fe", frame_err, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("par_clr", parity_err, 0);
        send_byte(8'h07, 1'b1, 1'b0);
        chk("par_ok_data", rd_data, 8'h07);
        chk("par_ok_count", count, 1);
        chk("par_ok_pe", parity_err, 0);
        pop();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
